kf8259_command_sequencer: RTL
=============================

Name: kf8259_command_sequencer

Overview:
- Consumes decoded write strobes and the internal data bus from the KF8259 bus control logic.
- Sequences the ICW1→ICW2→[ICW3]→[ICW4] initialization, then routes A0=1 writes to OCW1.
- Holds all programmed configuration and emits single-cycle OCW2/OCW3 command pulses for the priority resolver and in-service logic.

Parameters:
- None. Register widths are fixed by the 8259 programming model.

Ports:
- clock  in  1  system clock
- reset  in  1  async active-high
- internal_data_bus  in  8  data from bus control logic
- write_initial_command_word_1  in  1  ICW1 strobe, level, may last many cycles
- write_initial_command_word_2_to_4  in  1  A0=1 write strobe, level
- write_operation_control_word_1  in  1  same decode as above, ignored internally (A0=1 routing uses the 2_to_4 strobe)
- write_operation_control_word_2  in  1  OCW2 strobe, level
- write_operation_control_word_3  in  1  OCW3 strobe, level
- initialized  out  1  set on completing the sequence, cleared by ICW1/reset
- level_or_edge_triggered  out  1  ICW1.D3 (LTIM)
- single_or_cascade  out  1  ICW1.D1 (SNGL)
- interrupt_vector_address  out  5  ICW2.D7:3
- cascade_config  out  8  ICW3
- u8086_mode  out  1  ICW4.D0
- auto_eoi  out  1  ICW4.D1
- buffered_master  out  1  ICW4.D2
- buffered_mode  out  1  ICW4.D3
- special_fully_nested  out  1  ICW4.D4
- interrupt_mask  out  8  OCW1
- auto_rotate_mode  out  1  rotate in AEOI mode
- priority_bottom  out  3  lowest-priority IR level
- read_isr_select  out  1  0=IRR, 1=ISR
- special_mask_mode  out  1  SMM
- eoi_nonspecific  out  1  pulse
- eoi_specific  out  1  pulse, qualified by eoi_level
- rotate_on_eoi  out  1  pulse, accompanies either EOI pulse
- eoi_level  out  3  OCW2.D2:0, registered with the pulse
- poll_command  out  1  pulse

Behaviour:
Edge detection:
- prev_strobe is registered as the OR of all four used strobes.
- A command is accepted only in the cycle where its strobe=1 and prev_strobe=0. The bus data is sampled in that cycle.
- Registers update on that clock edge; pulses are high for exactly the following cycle (latency 1).
- A held strobe never re-triggers. Back-to-back commands need at least one deasserted cycle between them.

Reset (async):
- State CMD_READY, initialized=0.
- All configuration outputs 0, interrupt_mask=8'h00, priority_bottom=3'd7, all pulses 0.

States (CMD_READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4):
- ICW1 in any state:
  - Go to WAIT_ICW2; initialized=0.
  - Latch LTIM, SNGL, and IC4 (D0, internal).
  - Clear interrupt_mask, special_mask_mode, auto_rotate_mode, read_isr_select.
  - priority_bottom=7.
  - If IC4=0, clear all ICW4 outputs immediately.
- WAIT_ICW2 + A0 write:
  - Latch vector.
  - Next state: SNGL=0→WAIT_ICW3; else IC4=1→WAIT_ICW4; else CMD_READY with initialized=1.
- WAIT_ICW3 + A0 write:
  - Latch cascade_config.
  - Next state: IC4→WAIT_ICW4, else CMD_READY with initialized=1.
- WAIT_ICW4 + A0 write:
  - Latch ICW4 bits.
  - Go to CMD_READY; initialized=1.
- CMD_READY + A0 write: interrupt_mask=data.
- OCW2/OCW3 while not in CMD_READY: ignored, no state change.

OCW2 decode, CMD_READY only, on bits D7:5 (R,SL,EOI):
- 001: eoi_nonspecific.
- 011: eoi_specific, with eoi_level=D2:0.
- 101: eoi_nonspecific and rotate_on_eoi.
- 111: eoi_specific and rotate_on_eoi; also priority_bottom=D2:0.
- 100: auto_rotate_mode=1.
- 000: auto_rotate_mode=0.
- 110: priority_bottom=D2:0.
- 010: no operation.

OCW3 decode, CMD_READY only:
- If D1=1: read_isr_select=D0.
- If D6=1: special_mask_mode=D5.
- If D2=1: poll_command pulse.

Reset mid-sequence:
- Returns to CMD_READY/uninitialized; any pending pulse is cleared.

Decomposition:
- Package kf8259_pkg: state enum, OCW2 command encodings (3-bit constants), and the reset value for priority_bottom.
- Sub-module kf8259_strobe_edge: prev register plus rising-edge qualify for the strobe OR.
- Remaining logic is the FSM plus configuration registers in one module.

Test Plan:
- Reset, then ICW1=8'h13, ICW2=8'h08 → WAIT_ICW4 reached; ICW4=8'h01 → initialized=1, vector=5'h01, u8086_mode=1, single_or_cascade=1.
- ICW1=8'h11, ICW2=8'h20, ICW3=8'h04, ICW4=8'h1F → cascade_config=8'h04; all ICW4 bits=1; initialized asserts one cycle after the ICW4 edge.
- After initialization, A0 write 8'hA5 held for 5 cycles → interrupt_mask=8'hA5 written once; OCW2 8'h20 → eoi_nonspecific high exactly 1 cycle.
- OCW2 8'hE3 → eoi_specific=1, rotate_on_eoi=1, eoi_level=3, priority_bottom=3; OCW2 8'hC5 → priority_bottom=5 with no pulse.
- OCW3 8'h0B → read_isr_select=1; OCW3 8'h68 → special_mask_mode=1; OCW3 8'h0C → poll_command pulse.
- ICW1 mid-sequence (after ICW2) → back to WAIT_ICW2 and mask cleared; async reset asserted mid-OCW2 pulse → pulse drops immediately and all outputs return to reset values.

Source files
------------

// File: rtl/kf8259_pkg.sv
// kf8259_pkg: shared state encoding, OCW2 command codes and reset constants for the command sequencer
package kf8259_pkg;
    typedef enum logic [1:0] {CMD_READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4} cmd_state_t;
    localparam int NUM_STROBES = 4;
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;
    localparam logic [2:0] PRIORITY_BOTTOM_RESET = 3'd7;
endpackage

// File: rtl/kf8259_strobe_edge.sv
// kf8259_strobe_edge: qualifies each write strobe to the first cycle after all strobes were idle
module kf8259_strobe_edge
    import kf8259_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_STROBES-1:0] strobe,
    output logic [NUM_STROBES-1:0] fire
);
    logic prev_strobe;

    always_ff @(posedge clock or posedge reset)
        if (reset) prev_strobe <= 1'b0;
        else       prev_strobe <= |strobe;

    assign fire = strobe & {NUM_STROBES{~prev_strobe}};
endmodule

// File: rtl/kf8259_command_sequencer.sv
// kf8259_command_sequencer: ICW/OCW sequencing, configuration registers and OCW2/OCW3 command pulses
module kf8259_command_sequencer
    import kf8259_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] internal_data_bus,
    input  logic       write_initial_command_word_1,
    input  logic       write_initial_command_word_2_to_4,
    input  logic       write_operation_control_word_1,
    input  logic       write_operation_control_word_2,
    input  logic       write_operation_control_word_3,
    output logic       initialized,
    output logic       level_or_edge_triggered,
    output logic       single_or_cascade,
    output logic [4:0] interrupt_vector_address,
    output logic [7:0] cascade_config,
    output logic       u8086_mode,
    output logic       auto_eoi,
    output logic       buffered_master,
    output logic       buffered_mode,
    output logic       special_fully_nested,
    output logic [7:0] interrupt_mask,
    output logic       auto_rotate_mode,
    output logic [2:0] priority_bottom,
    output logic       read_isr_select,
    output logic       special_mask_mode,
    output logic       eoi_nonspecific,
    output logic       eoi_specific,
    output logic       rotate_on_eoi,
    output logic [2:0] eoi_level,
    output logic       poll_command
);
    cmd_state_t state;
    logic       ic4;
    logic       icw1_fire, a0_fire, ocw2_fire, ocw3_fire;
    logic [7:0] d;
    logic       unused_ocw1;

    // OCW1 shares the A0=1 decode; the 2_to_4 strobe already carries it
    assign unused_ocw1 = write_operation_control_word_1;
    assign d = internal_data_bus;

    kf8259_strobe_edge u_edge (
        .clock  (clock),
        .reset  (reset),
        .strobe ({write_operation_control_word_3, write_operation_control_word_2,
                  write_initial_command_word_2_to_4, write_initial_command_word_1}),
        .fire   ({ocw3_fire, ocw2_fire, a0_fire, icw1_fire})
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                    <= CMD_READY;
            ic4                      <= 1'b0;
            initialized              <= 1'b0;
            level_or_edge_triggered  <= 1'b0;
            single_or_cascade        <= 1'b0;
            interrupt_vector_address <= 5'd0;
            cascade_config           <= 8'h00;
            u8086_mode               <= 1'b0;
            auto_eoi                 <= 1'b0;
            buffered_master          <= 1'b0;
            buffered_mode            <= 1'b0;
            special_fully_nested     <= 1'b0;
            interrupt_mask           <= 8'h00;
            auto_rotate_mode         <= 1'b0;
            priority_bottom          <= PRIORITY_BOTTOM_RESET;
            read_isr_select          <= 1'b0;
            special_mask_mode        <= 1'b0;
            eoi_nonspecific          <= 1'b0;
            eoi_specific             <= 1'b0;
            rotate_on_eoi            <= 1'b0;
            eoi_level                <= 3'd0;
            poll_command             <= 1'b0;
        end else begin
            eoi_nonspecific <= 1'b0;
            eoi_specific    <= 1'b0;
            rotate_on_eoi   <= 1'b0;
            poll_command    <= 1'b0;
            if (icw1_fire) begin
                state                   <= WAIT_ICW2;
                initialized             <= 1'b0;
                level_or_edge_triggered <= d[3];
                single_or_cascade       <= d[1];
                ic4                     <= d[0];
                interrupt_mask          <= 8'h00;
                special_mask_mode       <= 1'b0;
                auto_rotate_mode        <= 1'b0;
                read_isr_select         <= 1'b0;
                priority_bottom         <= PRIORITY_BOTTOM_RESET;
                if (!d[0]) begin
                    u8086_mode           <= 1'b0;
                    auto_eoi             <= 1'b0;
                    buffered_master      <= 1'b0;
                    buffered_mode        <= 1'b0;
                    special_fully_nested <= 1'b0;
                end
            end else if (a0_fire) begin
                case (state)
                    WAIT_ICW2: begin
                        interrupt_vector_address <= d[7:3];
                        state       <= !single_or_cascade ? WAIT_ICW3 : ic4 ? WAIT_ICW4 : CMD_READY;
                        initialized <= single_or_cascade && !ic4;
                    end
                    WAIT_ICW3: begin
                        cascade_config <= d;
                        state          <= ic4 ? WAIT_ICW4 : CMD_READY;
                        initialized    <= !ic4;
                    end
                    WAIT_ICW4: begin
                        u8086_mode           <= d[0];
                        auto_eoi             <= d[1];
                        buffered_master      <= d[2];
                        buffered_mode        <= d[3];
                        special_fully_nested <= d[4];
                        state                <= CMD_READY;
                        initialized          <= 1'b1;
                    end
                    default: interrupt_mask <= d;
                endcase
            end else if (state == CMD_READY) begin
                if (ocw2_fire) begin
                    case (d[7:5])
                        OCW2_NS_EOI: eoi_nonspecific <= 1'b1;
                        OCW2_SP_EOI: begin
                            eoi_specific <= 1'b1;
                            eoi_level    <= d[2:0];
                        end
                        OCW2_ROT_NS_EOI: begin
                            eoi_nonspecific <= 1'b1;
                            rotate_on_eoi   <= 1'b1;
                        end
                        OCW2_ROT_SP_EOI: begin
                            eoi_specific    <= 1'b1;
                            rotate_on_eoi   <= 1'b1;
                            eoi_level       <= d[2:0];
                            priority_bottom <= d[2:0];
                        end
                        OCW2_ROT_AEOI_SET: auto_rotate_mode <= 1'b1;
                        OCW2_ROT_AEOI_CLR: auto_rotate_mode <= 1'b0;
                        OCW2_SET_PRIO:     priority_bottom  <= d[2:0];
                        default: ;
                    endcase
                end
                if (ocw3_fire) begin
                    if (d[1]) read_isr_select   <= d[0];
                    if (d[6]) special_mask_mode <= d[5];
                    if (d[2]) poll_command      <= 1'b1;
                end
            end
        end
    end
endmodule
